// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int WORD_W     = 32;
  localparam int PROD_W     = 65;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a two's-complement word; -2^31 maps to 2^31 as unsigned.
  function automatic logic [WORD_W-1:0] abs_val(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: cleared on start, counts busy cycles, flags the last one.
module iter_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr)
      count_next = '0;
    else if (inc)
      count_next = count_reg + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign count    = count_reg;
  assign terminal = (count_reg == CNT_W'(ITER_COUNT - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit radix-2 Booth multiplier and non-restoring divider with a
// fixed 32-cycle latency and a one-cycle completion pulse.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] data_operandA,
  input  logic [WORD_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [WORD_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY
);

  state_t state_reg;
  state_t state_next;

  logic [PROD_W-1:0] prod_reg;
  logic [PROD_W-1:0] prod_next;
  logic [WORD_W-1:0] op_reg;
  logic              neg_q_reg;
  logic              div_zero_reg;
  logic              div_ovf_reg;

  logic              load_mult;
  logic              load_div;
  logic              start;
  logic              step;
  logic              finish;
  logic              terminal;
  logic [CNT_W-1:0]  iter_count;

  logic [WORD_W:0]   booth_sum;
  logic [PROD_W-1:0] mult_next;
  logic [WORD_W:0]   rem_shift;
  logic [WORD_W:0]   rem_new;
  logic [PROD_W-1:0] div_next;
  logic [WORD_W-1:0] result_next;
  logic              exc_next;

  iter_counter u_iter_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (start),
    .inc      (step),
    .count    (iter_count),
    .terminal (terminal)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: a clean start pre-empts whatever is in progress
  always_comb begin
    state_next = state_reg;
    if (load_mult)
      state_next = MULT;
    else if (load_div)
      state_next = DIV;
    else begin
      case (state_reg)
        IDLE:     state_next = IDLE;
        MULT,
        DIV:      state_next = terminal ? DONE : state_reg;
        DONE:     state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    load_mult      = ctrl_MULT & ~ctrl_DIV;
    load_div       = ctrl_DIV & ~ctrl_MULT;
    start          = load_mult | load_div;
    step           = ((state_reg == MULT) || (state_reg == DIV)) && !start;
    finish         = step && terminal;
    data_resultRDY = (state_reg == DONE);
  end

  // Booth step on a 33-bit accumulator so a -2^31 multiplicand cannot overflow
  always_comb begin
    case (prod_reg[1:0])
      2'b01:   booth_sum = {prod_reg[PROD_W-1], prod_reg[PROD_W-1:WORD_W+1]}
                           + {op_reg[WORD_W-1], op_reg};
      2'b10:   booth_sum = {prod_reg[PROD_W-1], prod_reg[PROD_W-1:WORD_W+1]}
                           - {op_reg[WORD_W-1], op_reg};
      default: booth_sum = {prod_reg[PROD_W-1], prod_reg[PROD_W-1:WORD_W+1]};
    endcase
    mult_next = {booth_sum, prod_reg[WORD_W:1]};
  end

  // Non-restoring step: prod_reg holds {remainder[32:0], quotient[31:0]}
  always_comb begin
    rem_shift = {prod_reg[PROD_W-2:WORD_W], prod_reg[WORD_W-1]};
    if (prod_reg[PROD_W-1])
      rem_new = rem_shift + {1'b0, op_reg};
    else
      rem_new = rem_shift - {1'b0, op_reg};
    div_next = {rem_new, prod_reg[WORD_W-2:0], ~rem_new[WORD_W]};
  end

  always_comb begin
    prod_next   = (state_reg == MULT) ? mult_next : div_next;
    result_next = '0;
    exc_next    = 1'b0;
    if (state_reg == MULT) begin
      result_next = mult_next[WORD_W:1];
      exc_next    = !((&mult_next[PROD_W-1:WORD_W]) || !(|mult_next[PROD_W-1:WORD_W]));
    end else if (div_zero_reg) begin
      result_next = '0;
      exc_next    = 1'b1;
    end else begin
      result_next = neg_q_reg ? (~div_next[WORD_W-1:0] + 1'b1) : div_next[WORD_W-1:0];
      exc_next    = div_ovf_reg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg       <= '0;
      op_reg         <= '0;
      neg_q_reg      <= 1'b0;
      div_zero_reg   <= 1'b0;
      div_ovf_reg    <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      if (load_mult) begin
        prod_reg <= {{WORD_W{1'b0}}, data_operandB, 1'b0};
        op_reg   <= data_operandA;
      end else if (load_div) begin
        prod_reg     <= {{(WORD_W+1){1'b0}}, abs_val(data_operandA)};
        op_reg       <= abs_val(data_operandB);
        neg_q_reg    <= data_operandA[WORD_W-1] ^ data_operandB[WORD_W-1];
        div_zero_reg <= (data_operandB == '0);
        div_ovf_reg  <= (data_operandA == {1'b1, {(WORD_W-1){1'b0}}}) &&
                        (data_operandB == {WORD_W{1'b1}});
      end else if (step) begin
        prod_reg <= prod_next;
      end
      if (finish) begin
        data_result    <= result_next;
        data_exception <= exc_next;
      end
    end
  end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-004 SHALL have: data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-005 SHALL have: ctrl_MULT  input  1  start-multiply pulse; operands captured on the same edge.
REQ-006 SHALL have: ctrl_DIV  input  1  start-divide pulse; operands captured on the same edge.
REQ-007 SHALL have: data_result  output  32  low 32 bits of the product, or the quotient.
REQ-008 SHALL have: data_exception  output  1  multiply overflow, divide-by-zero or divide overflow.
REQ-009 SHALL have: data_resultRDY  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, MULT, DIV and DONE.
REQ-011 Start SHALL occur on an edge where exactly one of ctrl_MULT and ctrl_DIV is 1 (the capture edge E0); A and B SHALL be latched and the state SHALL become MULT or DIV.
REQ-012 If ctrl_MULT and ctrl_DIV are both 1, the edge SHALL be ignored: no capture and no state change.
REQ-013 Multiply SHALL use radix-2 Booth, one iteration per cycle, 32 iterations on edges E1..E32, with a 65-bit product register.
REQ-014 Divide SHALL be non-restoring on operand magnitudes, one quotient bit per cycle on edges E1..E32, followed by a sign fix (quotient negated iff signs differ); quotient SHALL truncate toward zero; remainder is discarded.
REQ-015 On E32 the state SHALL become DONE, and data_result and data_exception SHALL be registered.
REQ-016 data_resultRDY SHALL be 1 only in the DONE cycle (E32 to E33); at E33 the state SHALL become IDLE.
REQ-017 Latency SHALL be fixed at 32 cycles for every operation, including exceptional ones.
REQ-018 Multiply exception SHALL be 1 iff product[63:31] is not all-equal (for example, -2^31 x -1).
REQ-019 Divide with B = 0 SHALL give result 0x00000000 and exception 1.
REQ-020 -2^31 / -1 SHALL give result 0x80000000 and exception 1.
REQ-021 A valid start in any state (MULT, DIV or DONE) SHALL abort the current operation and restart from E0 with the new operands; the aborted operation SHALL produce no RDY pulse.
REQ-022 data_result and data_exception SHALL hold their last completed values until the next DONE.
REQ-023 Operand inputs SHALL be don't-care after E0.

Reset
REQ-024 reset_n = 0 SHALL immediately force: state IDLE, iteration counter 0, data_result 0, data_exception 0, data_resultRDY 0.
REQ-025 Reset mid-operation SHALL abort the operation; no RDY pulse SHALL follow after release.
REQ-026 The first start SHALL be honoured on the first rising edge with reset_n = 1.

Structure
REQ-027 Package multdiv_pkg SHALL hold:
- the state enum {IDLE, MULT, DIV, DONE};
- ITER_COUNT = 32;
- WORD_W = 32;
- PROD_W = 65.
REQ-028 The 6-bit iteration counter SHALL be sub-module iter_counter, with synchronous clear on start, increment while busy, and terminal flag at 31; all other logic SHALL be in multdiv_unit.
REQ-029 Adders SHALL be behavioural 32/33-bit; no gate-level requirement applies.

Verification
REQ-030 MULT 7 x -3 -> result 0xFFFFFFEB, exception 0, RDY high exactly 32 cycles after E0 for exactly 1 cycle.
REQ-031 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; MULT 0x80000000 x 0xFFFFFFFF -> exception 1.
REQ-032 DIV -100 / 7 -> result 0xFFFFFFF2 (-14), exception 0; DIV 100 / -7 -> 0xFFFFFFF2.
REQ-033 DIV 5 / 0 -> result 0, exception 1 after 32 cycles; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
REQ-034 DIV 100/10 started, then MULT 6 x 7 started 10 cycles later -> single RDY pulse 32 cycles after the second E0, result 42; no pulse for the divide.
REQ-035 reset_n low at cycle 15 of a MULT -> all outputs 0 asynchronously, no RDY pulse after release; ctrl_MULT and ctrl_DIV both high -> no RDY pulse.
